stopwatch_ctrl: RTL and testbench

Sequencing controller for the timebase counters: takes a single-cycle tick from a clock divider and two edge-detected button pulses, runs a start/stop/lap/clear state machine, and drives a cascaded centisecond/second/minute counter chain with carry enables. It sits between the button edge detectors and divider on one side and the 7-segment display decode on the other. It owns all sequencing decisions, so the counters downstream never see raw buttons.

---
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- start/stop/lap/clear sequencer and cascaded timebase
//
// Takes a one-cycle divider tick and two edge-detected button pulses. It runs
// the IDLE/RUN/LAP/STOP state machine and drives a centisecond/second/minute
// counter chain. The lap snapshot freezes the display while counting goes on
// underneath.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous, active-low; clears all state while low
//   tick      one-cycle count strobe (100 Hz nominal)
//   btn_ss    one-cycle start/stop pulse
//   btn_lr    one-cycle lap/reset pulse
//   cs        displayed centiseconds (0..CS_MAX-1)
//   sec       displayed seconds      (0..SEC_MAX-1)
//   min       displayed minutes      (0..MIN_MAX-1)
//   running   high in RUN or LAP
//   lap_hold  high in LAP (display shows the snapshot)
//   overflow  sticky, set when the minute field wraps
module stopwatch_ctrl #(
  parameter int CS_MAX  = 100,
  parameter int SEC_MAX = 60,
  parameter int MIN_MAX = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [6:0] cs,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  state_t     state, state_nxt;
  logic [6:0] cs_q, cs_snap;
  logic [5:0] sec_q, sec_snap;
  logic [5:0] min_q, min_snap;
  logic       ovf_q;

  logic count_en, cs_wrap, sec_wrap, min_wrap;
  logic snap_en, clear;

  // btn_ss is tested first in every state, so it wins over btn_lr.
  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_ss) state_nxt = RUN;
      end
      RUN, LAP: begin
        if (btn_ss) begin
          state_nxt = STOP;
        end else if (btn_lr) begin
          state_nxt = LAP;
          snap_en   = 1'b1;
        end
      end
      STOP: begin
        if (btn_ss) begin
          state_nxt = RUN;
        end else if (btn_lr) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Enable is taken from the registered state, so a stop pulse that arrives
  // with a tick still counts it, and a start pulse that arrives with a tick
  // does not.
  assign count_en = ((state == RUN) || (state == LAP)) && tick;
  assign cs_wrap  = (cs_q  == 7'(CS_MAX - 1));
  assign sec_wrap = (sec_q == 6'(SEC_MAX - 1));
  assign min_wrap = (min_q == 6'(MIN_MAX - 1));

  // The whole carry chain resolves combinationally and updates on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      cs_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
      ovf_q <= 1'b0;
    end else if (count_en) begin
      cs_q <= cs_wrap ? '0 : cs_q + 7'd1;
      if (cs_wrap) begin
        sec_q <= sec_wrap ? '0 : sec_q + 6'd1;
        if (sec_wrap) begin
          min_q <= min_wrap ? '0 : min_q + 6'd1;
          if (min_wrap) ovf_q <= 1'b1;
        end
      end
    end
  end

  // The snapshot takes the pre-edge live value, so a coincident tick is not
  // included in it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_snap  <= '0;
      sec_snap <= '0;
      min_snap <= '0;
    end else if (clear) begin
      cs_snap  <= '0;
      sec_snap <= '0;
      min_snap <= '0;
    end else if (snap_en) begin
      cs_snap  <= cs_q;
      sec_snap <= sec_q;
      min_snap <= min_q;
    end
  end

  assign running  = (state == RUN) || (state == LAP);
  assign lap_hold = (state == LAP);
  assign overflow = ovf_q;
  assign cs       = lap_hold ? cs_snap  : cs_q;
  assign sec      = lap_hold ? sec_snap : sec_q;
  assign min      = lap_hold ? min_snap : min_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl. It runs one full-size instance and one small
// instance (4/2/2) for the overflow cases. The reference model keeps elapsed
// time as a single tick total and derives the display fields with div/mod.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, btn_ss = 1'b0, btn_lr = 1'b0;

  logic [6:0] cs_a, cs_b;
  logic [5:0] sec_a, sec_b, min_a, min_b;
  logic       run_a, run_b, lap_a, lap_b, ovf_a, ovf_b;

  always #10 clk = ~clk;

  stopwatch_ctrl u_big (
    .clk(clk), .reset(reset), .tick(tick), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .cs(cs_a), .sec(sec_a), .min(min_a),
    .running(run_a), .lap_hold(lap_a), .overflow(ovf_a)
  );

  stopwatch_ctrl #(.CS_MAX(4), .SEC_MAX(2), .MIN_MAX(2)) u_small (
    .clk(clk), .reset(reset), .tick(tick), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .cs(cs_b), .sec(sec_b), .min(min_b),
    .running(run_b), .lap_hold(lap_b), .overflow(ovf_b)
  );

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;
  int csm[2]  = '{100, 4};
  int secm[2] = '{60, 2};
  int minm[2] = '{60, 2};
  int mode[2], total[2], snap[2];
  bit ovf[2];

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mode[d] = M_IDLE; total[d] = 0; snap[d] = 0; ovf[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit t, input bit s, input bit l);
    int old;
    bit live;
    for (int d = 0; d < 2; d++) begin
      old  = total[d];
      live = (mode[d] == M_RUN) || (mode[d] == M_LAP);
      if (live && t) begin
        total[d]++;
        if (total[d] == csm[d] * secm[d] * minm[d]) begin
          total[d] = 0;
          ovf[d]   = 1'b1;
        end
      end
      if (s) begin
        mode[d] = live ? M_STOP : M_RUN;
      end else if (l) begin
        if (live) begin
          mode[d] = M_LAP;
          snap[d] = old;
        end else if (mode[d] == M_STOP) begin
          mode[d] = M_IDLE; total[d] = 0; snap[d] = 0; ovf[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int shown;
    for (int d = 0; d < 2; d++) begin
      shown = (mode[d] == M_LAP) ? snap[d] : total[d];
      check({tag, d == 0 ? "/A.cs" : "/B.cs"}, d == 0 ? 32'(cs_a) : 32'(cs_b),
            shown % csm[d]);
      check({tag, d == 0 ? "/A.sec" : "/B.sec"}, d == 0 ? 32'(sec_a) : 32'(sec_b),
            (shown / csm[d]) % secm[d]);
      check({tag, d == 0 ? "/A.min" : "/B.min"}, d == 0 ? 32'(min_a) : 32'(min_b),
            shown / (csm[d] * secm[d]));
      check({tag, d == 0 ? "/A.run" : "/B.run"}, d == 0 ? 32'(run_a) : 32'(run_b),
            32'((mode[d] == M_RUN) || (mode[d] == M_LAP)));
      check({tag, d == 0 ? "/A.lap" : "/B.lap"}, d == 0 ? 32'(lap_a) : 32'(lap_b),
            32'(mode[d] == M_LAP));
      check({tag, d == 0 ? "/A.ovf" : "/B.ovf"}, d == 0 ? 32'(ovf_a) : 32'(ovf_b),
            32'(ovf[d]));
    end
  endtask

  task automatic step(input bit t, input bit s, input bit l);
    tick = t; btn_ss = s; btn_lr = l;
    @(posedge clk);
    model_edge(t, s, l);
    #1;
    check_all("step");
    tick = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic show_a(input string tag, input int m, input int s, input int c);
    check({tag, ".cs"},  32'(cs_a),  c);
    check({tag, ".sec"}, 32'(sec_a), s);
    check({tag, ".min"}, 32'(min_a), m);
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // basic run / stop
    step(0, 1, 0);
    ticks(250);
    show_a("run250", 0, 2, 50);
    check("run250.running", 32'(run_a), 1);
    step(0, 1, 0);
    ticks(10);
    show_a("stopped", 0, 2, 50);
    check("stopped.running", 32'(run_a), 0);

    // single-edge carry into minutes
    step(0, 0, 1);
    step(0, 1, 0);
    ticks(5999);
    show_a("pre_carry", 0, 59, 99);
    step(1, 0, 0);
    show_a("carry", 1, 0, 0);

    // lap hold and re-capture
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    ticks(500);
    step(0, 0, 1);
    check("lap.hold", 32'(lap_a), 1);
    ticks(300);
    show_a("lap_frozen", 0, 5, 0);
    step(0, 0, 1);
    show_a("lap_recap", 0, 8, 0);
    step(0, 1, 0);
    show_a("lap_stop", 0, 8, 0);
    check("lap_stop.hold", 32'(lap_a), 0);

    // overflow on the small instance
    step(0, 0, 1);
    step(0, 1, 0);
    ticks(16);
    check("ovf.cs",  32'(cs_b), 0);
    check("ovf.sec", 32'(sec_b), 0);
    check("ovf.min", 32'(min_b), 0);
    check("ovf.flag", 32'(ovf_b), 1);
    step(0, 1, 0);
    step(0, 0, 1);
    check("ovf_clr.flag", 32'(ovf_b), 0);
    step(1, 0, 0);
    check("ovf_clr.idle_cs", 32'(cs_b), 0);

    // coincident inputs
    step(0, 1, 0);
    ticks(7);
    step(0, 1, 1);
    check("ss_lr.running", 32'(run_a), 0);
    check("ss_lr.hold", 32'(lap_a), 0);
    step(1, 1, 0);
    check("start_tick.cs", 32'(cs_a), 7);
    step(1, 1, 0);
    check("stop_tick.cs", 32'(cs_a), 8);
    check("stop_tick.running", 32'(run_a), 0);
    step(1, 0, 1);
    show_a("clr_tick", 0, 0, 0);

    // asynchronous reset between edges
    step(0, 1, 0);
    ticks(123);
    show_a("pre_rst", 0, 1, 23);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    show_a("async_rst", 0, 0, 0);
    check_all("async_rst");
    #2;
    reset = 1'b1;
    step(0, 0, 1);
    check("post_rst.running", 32'(run_a), 0);
    step(1, 0, 0);
    check("post_rst.idle_cs", 32'(cs_a), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 14) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
